fir_mac: RTL and testbench

//  Downstream consumer of the filters-IP sample window writer. Snoops the window write stream
//  (owe/addr/do/done) as it goes out to BRAM and multiply-accumulates each sample against a
//  per-tap coefficient. Once the window is complete, it rounds, shifts and saturates the sum

---
 rtl/fir_mac_if.sv | 33 +++
 rtl/fir_mac.sv | 149 ++++++++++++++
 tb/tb_fir_mac.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_if.sv
// Window-snoop / coefficient / result bundle for fir_mac.
// master: the side that drives the sample stream, coefficient writes and y_ready.
// slave : the fir_mac block itself.
interface fir_mac_if #(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 12,
  parameter int COEF_SIZE = 16
);
  logic                 s_we;
  logic [ADDR_SIZE-1:0] s_addr;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_done;
  logic                 coef_we;
  logic [ADDR_SIZE-1:0] coef_addr;
  logic [COEF_SIZE-1:0] coef_di;
  logic [DATA_SIZE-1:0] y;
  logic                 y_valid;
  logic                 y_ready;
  logic                 busy;
  logic                 ovr;
  logic                 frm_err;
  logic                 clr_err;

  modport master (
    output s_we, s_addr, s_data, s_done, coef_we, coef_addr, coef_di, y_ready, clr_err,
    input  y, y_valid, busy, ovr, frm_err
  );

  modport slave (
    input  s_we, s_addr, s_data, s_done, coef_we, coef_addr, coef_di, y_ready, clr_err,
    output y, y_valid, busy, ovr, frm_err
  );
endinterface

// File: rtl/fir_mac.sv
// fir_mac: snoops the sample-window write stream, multiplies each sample by its
// per-tap coefficient and accumulates; at window end rounds, shifts and saturates
// the sum into one filtered sample offered on a valid/ready handshake.
// Out of reset all coefficients are 1, so with SHIFT=2 and M=4 it is a moving average.
module fir_mac #(
  parameter int M         = 4,
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 12,
  parameter int COEF_SIZE = 16,
  parameter int SHIFT     = 2
) (
  input logic      clk,
  input logic      rst,
  fir_mac_if.slave bus
);
  localparam int IDX_W    = (M > 1) ? $clog2(M) : 1;
  localparam int PROD_W   = DATA_SIZE + 1 + COEF_SIZE;
  localparam int ACC_SIZE = PROD_W + $clog2(M);
  localparam int CNT_W    = $clog2(M + 1) + 1;
  localparam logic signed [ACC_SIZE:0] RND  =
    (SHIFT > 0) ? ((ACC_SIZE+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_SIZE:0] YMAX = (ACC_SIZE+1)'((1 << DATA_SIZE) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_FLUSH, S_SCALE, S_OUT} state_t;

  state_t                      state;
  logic signed [COEF_SIZE-1:0] coef [M];
  logic signed [PROD_W-1:0]    prod_p1;
  logic                        vld_p1;
  logic signed [ACC_SIZE-1:0]  acc;
  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_SIZE:0]    rnd_p2;
  logic                        vld_p2;
  logic [DATA_SIZE-1:0]        y_q;
  logic                        y_valid_q;
  logic                        ovr_q;
  logic                        frm_err_q;

  logic samp_ok;
  logic accept;
  logic coef_ok;

  // Round half up, then arithmetic shift; one extra bit keeps the rounding add from wrapping.
  function automatic logic signed [ACC_SIZE:0] round_shift(input logic signed [ACC_SIZE-1:0] a);
    logic signed [ACC_SIZE:0] t;
    t = (ACC_SIZE+1)'(a) + RND;
    return t >>> SHIFT;
  endfunction

  // Clamp into the unsigned output code range.
  function automatic logic [DATA_SIZE-1:0] saturate(input logic signed [ACC_SIZE:0] r);
    if (r < 0)         return '0;
    else if (r > YMAX) return '1;
    else               return r[DATA_SIZE-1:0];
  endfunction

  assign samp_ok = bus.s_we & (bus.s_addr < ADDR_SIZE'(M));
  assign accept  = samp_ok & ((state == S_IDLE) | (state == S_ACC));
  assign coef_ok = bus.coef_we & (bus.coef_addr < ADDR_SIZE'(M)) &
                   ((state == S_IDLE) | (state == S_OUT));

  // Coefficient bank: writable only while no window is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < M; k++) coef[k] <= COEF_SIZE'(1);
    end else if (coef_ok) begin
      coef[bus.coef_addr[IDX_W-1:0]] <= bus.coef_di;
    end
  end

  // Stage p1: one-cycle multiply of the accepted sample (zero-extended to signed) by its coefficient.
  always_ff @(posedge clk) begin
    if (accept)
      prod_p1 <= PROD_W'(coef[bus.s_addr[IDX_W-1:0]]) * PROD_W'($signed({1'b0, bus.s_data}));
  end

  // Stage p2: registered round/shift of the finished accumulator, saturated on the next cycle.
  always_ff @(posedge clk) begin
    if ((state == S_SCALE) && !vld_p2) rnd_p2 <= round_shift(acc);
  end

  // Window FSM: accumulate, flush, scale, then hold the result until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovr_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (bus.clr_err) begin
        ovr_q     <= 1'b0;
        frm_err_q <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc   <= '0;
            cnt   <= CNT_W'(1);
            state <= bus.s_done ? S_FLUSH : S_ACC;
          end
        end
        S_ACC: begin
          if (vld_p1) acc <= acc + ACC_SIZE'(prod_p1);
          if (accept && (cnt != '1)) cnt <= cnt + CNT_W'(1);
          if (bus.s_done) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (vld_p1) acc <= acc + ACC_SIZE'(prod_p1);
          if (cnt != CNT_W'(M)) begin
            frm_err_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            state <= S_SCALE;
          end
        end
        S_SCALE: begin
          if (!vld_p2) begin
            vld_p2 <= 1'b1;
          end else begin
            vld_p2    <= 1'b0;
            y_q       <= saturate(rnd_p2);
            y_valid_q <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (samp_ok) ovr_q <= 1'b1;
          if (bus.y_ready) begin
            y_valid_q <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state != S_IDLE);
  assign bus.ovr     = ovr_q;
  assign bus.frm_err = frm_err_q;
endmodule

// File: tb/tb_fir_mac.sv
// Directed + randomized bench for fir_mac with a plain-arithmetic reference model.
module tb_fir_mac;
  localparam int M  = 4;
  localparam int SH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fir_mac_if #(.ADDR_SIZE(5), .DATA_SIZE(12), .COEF_SIZE(16)) bus ();

  fir_mac #(.M(M), .ADDR_SIZE(5), .DATA_SIZE(12), .COEF_SIZE(16), .SHIFT(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cm  [M];
  int win [M];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Filter output from the arithmetic definition: floor((sum + 2^(SH-1)) / 2^SH), clamped to 0..4095.
  function automatic int model_y();
    longint acc, t, q, d;
    acc = 0;
    for (int k = 0; k < M; k++) acc += longint'(cm[k]) * longint'(win[k]);
    d = longint'(1) << SH;
    t = acc + (d / 2);
    q = t / d;
    if ((t < 0) && ((t % d) != 0)) q = q - 1;
    if (q < 0) return 0;
    if (q > 4095) return 4095;
    return int'(q);
  endfunction

  task automatic set_coef(input int k, input int v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = k[4:0];
    bus.coef_di   = v[15:0];
    tick();
    bus.coef_we = 1'b0;
    if (k < M) cm[k] = v;
  endtask

  task automatic send_sample(input int i, input logic done);
    bus.s_we   = 1'b1;
    bus.s_addr = i[4:0];
    bus.s_data = win[i][11:0];
    bus.s_done = done;
    tick();
    bus.s_we   = 1'b0;
    bus.s_done = 1'b0;
  endtask

  task automatic send_win(input int n);
    for (int i = 0; i < n; i++) send_sample(i, i == n - 1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while ((bus.y_valid !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, bus.y_valid, 1);
  endtask

  task automatic accept_y(input string tag);
    bus.y_ready = 1'b1;
    tick();
    bus.y_ready = 1'b0;
    check({tag, "_vld_drop"}, bus.y_valid, 0);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  // Sends a full window (done with last sample), checks 3-edge latency and value.
  task automatic run_win(input string tag);
    send_win(M);
    check({tag, "_lat1"}, bus.y_valid, 0);
    tick();
    check({tag, "_lat2"}, bus.y_valid, 0);
    tick();
    check({tag, "_lat3"}, bus.y_valid, 0);
    tick();
    check({tag, "_lat_rise"}, bus.y_valid, 1);
    check({tag, "_y"}, bus.y, model_y());
  endtask

  initial begin
    int v;
    logic seen;
    bus.s_we = 0; bus.s_addr = 0; bus.s_data = 0; bus.s_done = 0;
    bus.coef_we = 0; bus.coef_addr = 0; bus.coef_di = 0;
    bus.y_ready = 0; bus.clr_err = 0;
    for (int k = 0; k < M; k++) cm[k] = 1;
    tick(); tick();
    check("rst_y", bus.y, 0);
    check("rst_valid", bus.y_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovr", bus.ovr, 0);
    check("rst_frm", bus.frm_err, 0);
    rst = 1'b0;
    tick();

    // Default moving average
    win = '{100, 200, 300, 400};
    run_win("avg");
    check("avg_250", bus.y, 250);
    check("avg_busy", bus.busy, 1);
    accept_y("avg");

    // Signed coefficients, then negative saturation
    set_coef(0, 4); set_coef(1, -4); set_coef(2, 0); set_coef(3, 0);
    win = '{500, 100, 7, 9};
    run_win("pos");
    check("pos_400", bus.y, 400);
    accept_y("pos");
    win = '{100, 500, 0, 0};
    run_win("neg");
    check("neg_sat0", bus.y, 0);
    accept_y("neg");

    // Full-scale high saturation, no accumulator wrap
    for (int k = 0; k < M; k++) set_coef(k, 32'h7FFF);
    win = '{4095, 4095, 4095, 4095};
    run_win("full");
    check("full_4095", bus.y, 4095);
    accept_y("full");

    // Overrun while result is held
    for (int k = 0; k < M; k++) set_coef(k, 1);
    win = '{100, 200, 300, 400};
    run_win("ovr1");
    for (int k = 0; k < M; k++) win[k] = int'($urandom_range(0, 4095));
    send_win(M);
    tick();
    check("ovr_set", bus.ovr, 1);
    check("ovr_y_hold", bus.y, 250);
    check("ovr_vld_hold", bus.y_valid, 1);
    accept_y("ovr1");
    win = '{4, 4, 4, 4};
    run_win("ovr3");
    check("ovr3_4", bus.y, 4);
    accept_y("ovr3");
    check("ovr_sticky", bus.ovr, 1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("ovr_clr", bus.ovr, 0);

    // Short window -> framing error, no output
    win = '{11, 22, 33, 44};
    send_win(3);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.y_valid === 1'b1) seen = 1'b1;
      tick();
    end
    check("frm_no_valid", seen, 0);
    check("frm_set", bus.frm_err, 1);
    check("frm_idle", bus.busy, 0);
    for (int k = 0; k < M; k++) win[k] = int'($urandom_range(0, 4095));
    run_win("frm_next");
    accept_y("frm_next");
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("frm_clr", bus.frm_err, 0);

    // Randomized windows, including ignored out-of-range coefficient writes
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < M; k++) begin
        if (it % 2 == 0) v = int'($urandom_range(0, 16)) - 8;
        else             v = int'($signed(16'($urandom)));
        set_coef(k, v);
      end
      set_coef(M + 1, int'($urandom_range(0, 65535)));
      for (int k = 0; k < M; k++) win[k] = int'($urandom_range(0, 4095));
      run_win($sformatf("rnd%0d", it));
      accept_y($sformatf("rnd%0d", it));
    end

    // Reset mid-window restores defaults
    for (int k = 0; k < M; k++) set_coef(k, int'($urandom_range(2, 50)));
    win = '{8, 8, 8, 8};
    send_sample(0, 1'b0);
    send_sample(1, 1'b0);
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.y_valid, 0);
    check("mid_rst_y", bus.y, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < M; k++) cm[k] = 1;
    tick();

    // Coefficient write during accumulation is ignored
    send_sample(0, 1'b0);
    send_sample(1, 1'b0);
    bus.coef_we = 1'b1; bus.coef_addr = 0; bus.coef_di = 16'd100;
    tick();
    bus.coef_we = 1'b0;
    send_sample(2, 1'b0);
    send_sample(3, 1'b1);
    wait_valid("rst8");
    check("rst8_y", bus.y, 8);
    accept_y("rst8");
    run_win("cwe_ign");
    check("cwe_ign_8", bus.y, 8);
    accept_y("cwe_ign");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
